// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: CPU and debug requester ports, memory port and error flags.
// slave = arbiter view; master = environment (requesters plus memory).
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_done;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              xfer_err;
  logic              err_sticky;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_done, dbg_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output xfer_err, err_sticky
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_done, dbg_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  xfer_err, err_sticky
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Registered round-robin arbiter sharing one ack-based memory port between CPU and debug, with a
// watchdog abort. Define MEM_ARB_DBG_PRIORITY_EN to make debug win every tie (fixed priority).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {StIdle, StBusy} state_e;
  typedef enum logic {OwnCpu, OwnDbg} owner_e;

  localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  owner_e            last_owner_q, last_owner_d;
  logic [7:0]        wdog_q, wdog_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dbg_gnt_q, dbg_gnt_d;
  logic              cpu_done_q, cpu_done_d;
  logic              dbg_done_q, dbg_done_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              xfer_err_q, xfer_err_d;
  logic              err_sticky_q, err_sticky_d;

  logic              win_dbg;
  logic [DATA_W-1:0] fin_rdata;

`ifdef MEM_ARB_DBG_PRIORITY_EN
  assign win_dbg = bus.dbg_req;
`else
  // On a tie the port that did not own the previous transfer wins.
  assign win_dbg = bus.dbg_req && (!bus.cpu_req || (last_owner_q == OwnCpu));
`endif

  // An aborted transfer returns zero instead of whatever is on mem_rdata.
  assign fin_rdata = bus.mem_ack ? bus.mem_rdata : '0;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    wdog_d       = wdog_q;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    cpu_done_d   = 1'b0;
    dbg_done_d   = 1'b0;
    xfer_err_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    err_sticky_d = err_sticky_q;

    unique case (state_q)
      StIdle: begin
        mem_req_d = 1'b0;
        if (bus.cpu_req || bus.dbg_req) begin
          state_d   = StBusy;
          mem_req_d = 1'b1;
          wdog_d    = 8'd0;
          if (win_dbg) begin
            last_owner_d = OwnDbg;
            dbg_gnt_d    = 1'b1;
            mem_we_d     = bus.dbg_we;
            mem_addr_d   = bus.dbg_addr;
            mem_wdata_d  = bus.dbg_wdata;
          end else begin
            last_owner_d = OwnCpu;
            cpu_gnt_d    = 1'b1;
            mem_we_d     = bus.cpu_we;
            mem_addr_d   = bus.cpu_addr;
            mem_wdata_d  = bus.cpu_wdata;
          end
        end
      end
      StBusy: begin
        // Ack on the watchdog's last cycle still completes normally.
        if (bus.mem_ack || (wdog_q == WdogLast)) begin
          state_d      = StIdle;
          mem_req_d    = 1'b0;
          wdog_d       = 8'd0;
          xfer_err_d   = !bus.mem_ack;
          err_sticky_d = err_sticky_q | !bus.mem_ack;
          if (last_owner_q == OwnDbg) begin
            dbg_done_d  = 1'b1;
            dbg_rdata_d = fin_rdata;
          end else begin
            cpu_done_d  = 1'b1;
            cpu_rdata_d = fin_rdata;
          end
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_owner_q <= OwnDbg;
      wdog_q       <= 8'd0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      cpu_done_q   <= 1'b0;
      dbg_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      xfer_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      wdog_q       <= wdog_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      cpu_done_q   <= cpu_done_d;
      dbg_done_q   <= dbg_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      xfer_err_q   <= xfer_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_q;
  assign bus.dbg_gnt    = dbg_gnt_q;
  assign bus.cpu_done   = cpu_done_q;
  assign bus.dbg_done   = dbg_done_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.xfer_err   = xfer_err_q;
  assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized transfers checked
// against a transaction-level model (winner rule, ack-or-timeout completion, held read data).
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int          TO = 15;
`ifdef MEM_ARB_DBG_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  bit          last_dbg;
  logic [15:0] exp_cpu_rdata;
  logic [15:0] exp_dbg_rdata;
  bit          exp_sticky;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".cpu_gnt"}, bus.cpu_gnt, 0);
    chk({tag, ".dbg_gnt"}, bus.dbg_gnt, 0);
    chk({tag, ".cpu_done"}, bus.cpu_done, 0);
    chk({tag, ".dbg_done"}, bus.dbg_done, 0);
    chk({tag, ".cpu_rdata"}, bus.cpu_rdata, 0);
    chk({tag, ".dbg_rdata"}, bus.dbg_rdata, 0);
    chk({tag, ".mem_req"}, bus.mem_req, 0);
    chk({tag, ".mem_we"}, bus.mem_we, 0);
    chk({tag, ".mem_addr"}, bus.mem_addr, 0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, ".xfer_err"}, bus.xfer_err, 0);
    chk({tag, ".err_sticky"}, bus.err_sticky, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    chk_zero(tag);
    rst = 1'b0;
    last_dbg = 1'b1;
    exp_cpu_rdata = '0;
    exp_dbg_rdata = '0;
    exp_sticky = 1'b0;
  endtask

  // Entered and left at a negedge. ack_k: BUSY edge on which mem_ack is sampled (>TO = never).
  task automatic xfer(input string tag, input bit rc, input bit rd,
                      input bit wc, input logic [15:0] ac, input logic [15:0] dc,
                      input bit wd, input logic [15:0] ad, input logic [15:0] dd,
                      input int ack_k);
    bit          win_dbg;
    bit          e_we;
    logic [15:0] e_addr, e_wdata, rv, other_rd;
    if (rc && rd) win_dbg = PRIO ? 1'b1 : !last_dbg;
    else          win_dbg = rd;
    e_we    = win_dbg ? wd : wc;
    e_addr  = win_dbg ? ad : ac;
    e_wdata = win_dbg ? dd : dc;

    bus.cpu_req = rc; bus.cpu_we = wc; bus.cpu_addr = ac; bus.cpu_wdata = dc;
    bus.dbg_req = rd; bus.dbg_we = wd; bus.dbg_addr = ad; bus.dbg_wdata = dd;
    @(negedge clk);
    chk({tag, ".cpu_gnt"}, bus.cpu_gnt, !win_dbg);
    chk({tag, ".dbg_gnt"}, bus.dbg_gnt, win_dbg);
    chk({tag, ".mem_req"}, bus.mem_req, 1);
    chk({tag, ".mem_we"}, bus.mem_we, e_we);
    chk({tag, ".mem_addr"}, bus.mem_addr, e_addr);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, e_wdata);
    last_dbg = win_dbg;
    // Requesters drop and scramble their fields once granted.
    bus.cpu_req = 0; bus.dbg_req = 0;
    bus.cpu_addr = 16'($urandom); bus.dbg_addr = 16'($urandom);
    bus.cpu_wdata = 16'($urandom); bus.dbg_wdata = 16'($urandom);
    bus.cpu_we = 1'($urandom); bus.dbg_we = 1'($urandom);

    for (int k = 1; k <= TO; k++) begin
      rv = 16'($urandom);
      bus.mem_ack = (k == ack_k);
      bus.mem_rdata = rv;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (k == ack_k || k == TO) begin
        if (k != ack_k) begin
          rv = '0;
          exp_sticky = 1'b1;
        end
        chk({tag, ".cpu_done"}, bus.cpu_done, !win_dbg);
        chk({tag, ".dbg_done"}, bus.dbg_done, win_dbg);
        chk({tag, ".xfer_err"}, bus.xfer_err, k != ack_k);
        chk({tag, ".mem_req_end"}, bus.mem_req, 0);
        chk({tag, ".err_sticky"}, bus.err_sticky, exp_sticky);
        if (win_dbg) exp_dbg_rdata = rv; else exp_cpu_rdata = rv;
        if (!e_we || k != ack_k) begin
          if (win_dbg) chk({tag, ".dbg_rdata"}, bus.dbg_rdata, rv);
          else         chk({tag, ".cpu_rdata"}, bus.cpu_rdata, rv);
        end
        other_rd = win_dbg ? bus.cpu_rdata : bus.dbg_rdata;
        chk({tag, ".other_rdata"}, other_rd, win_dbg ? exp_cpu_rdata : exp_dbg_rdata);
        break;
      end
      chk({tag, ".busy_req"}, bus.mem_req, 1);
      chk({tag, ".busy_addr"}, bus.mem_addr, e_addr);
      chk({tag, ".busy_wdata"}, bus.mem_wdata, e_wdata);
      chk({tag, ".busy_we"}, bus.mem_we, e_we);
      chk({tag, ".busy_done"}, {bus.cpu_done, bus.dbg_done, bus.cpu_gnt, bus.dbg_gnt}, 0);
    end
  endtask

  initial begin
    int sel;
    int ak;
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    do_reset("reset");

    // Single CPU read, ack one cycle after mem_req.
    xfer("cpu_rd", 1, 0, 0, 16'h0010, 16'h0000, 0, 16'h0, 16'h0, 1);

    // Ack while idle must be ignored.
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("idle_ack.done", {bus.cpu_done, bus.dbg_done, bus.mem_req, bus.xfer_err}, 0);
    chk("idle_ack.cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
    chk("idle_ack.dbg_rdata", bus.dbg_rdata, exp_dbg_rdata);

    // Both requesting from reset, four back-to-back transfers.
    do_reset("reset2");
    for (int i = 0; i < 4; i++)
      xfer("tie", 1, 1, 0, 16'h1000 + 16'(i), 16'h0, 0, 16'h2000 + 16'(i), 16'h0, 1);

    // Debug write, ack delayed 5 cycles.
    xfer("dbg_wr", 0, 1, 0, 16'h0, 16'h0, 1, 16'h0200, 16'h1234, 6);

    // Watchdog abort, then ack landing exactly on the timeout cycle.
    xfer("timeout", 1, 0, 0, 16'h0300, 16'h0, 0, 16'h0, 16'h0, TO + 5);
    xfer("ack_at_to", 1, 0, 0, 16'h0304, 16'h0, 0, 16'h0, 16'h0, TO);

    // Reset in the second BUSY cycle drops the transfer.
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0400;
    @(negedge clk);
    chk("rst_busy.gnt", bus.cpu_gnt, 1);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_busy");
    rst = 1'b0;
    last_dbg = 1'b1; exp_cpu_rdata = '0; exp_dbg_rdata = '0; exp_sticky = 1'b0;
    xfer("after_rst", 1, 0, 0, 16'h0500, 16'h0, 0, 16'h0, 16'h0, 2);

    // Randomized transfers.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) ak = TO + 3;
      else if ($urandom_range(0, 7) == 0) ak = TO;
      else ak = $urandom_range(1, 6);
      xfer("rand", sel != 1, sel != 0,
           1'($urandom), 16'($urandom), 16'($urandom),
           1'($urandom), 16'($urandom), 16'($urandom), ak);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
